// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: state encoding, default parameters and one-hot helper for the UART TX arbiter
package uart_arb_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} arb_state_e;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_D_WIDTH = 4;
    localparam int DEF_TIMEOUT = 16;
    localparam int MAX_REQ = 8;
    function automatic logic [MAX_REQ-1:0] onehot(input int idx);
        return MAX_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin selector; first request after ptr, wrapping
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx,
    output logic [N_REQ-1:0] oh
);
    logic [IW-1:0] cand;
    // Scan upward from the slot after the last grant and keep the first requester found
    always_comb begin
        valid = 1'b0;
        idx = '0;
        cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx = cand;
            end
        end
        oh = valid ? N_REQ'(onehot(int'(idx))) : '0;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to add a handshake watchdog that aborts with a one-cycle tx_err pulse.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*D_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         owner,
    output logic                     arb_busy,
    output logic                     tx_ena,
    output logic [D_WIDTH-1:0]       tx_data,
    input  logic                     tx_busy,
    output logic                     tx_err
);
    if (N_REQ < 2 || N_REQ > MAX_REQ || TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [D_WIDTH-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               tx_ena_q, tx_ena_d;
    logic [D_WIDTH-1:0] tx_data_q, tx_data_d;
    logic               tx_err_q, tx_err_d;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [N_REQ-1:0]   pick_oh;
    logic               timed_out;

    uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx),
        .oh    (pick_oh)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign timed_out = cnt_q == CW'(TIMEOUT - 1);
    // Count cycles spent in a wait state; any state change restarts the count
    always_comb begin
        cnt_d = ((state_q == WAIT_BUSY || state_q == WAIT_DONE) && state_d == state_q) ? cnt_q + 1'b1 : '0;
    end
    // Watchdog counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    assign timed_out = 1'b0;
`endif

    // Next-state and registered-output logic for the grant/launch/wait handshake
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        hold_d = hold_q;
        gnt_d = '0;
        owner_d = owner_q;
        tx_ena_d = 1'b0;
        tx_data_d = tx_data_q;
        tx_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid && !tx_busy) begin
                    state_d = LAUNCH;
                    gnt_d = pick_oh;
                    owner_d = pick_oh;
                    ptr_d = pick_idx;
                    for (int i = 0; i < N_REQ; i++)
                        if (pick_oh[i]) hold_d = req_data[i*D_WIDTH +: D_WIDTH];
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
                tx_ena_d = 1'b1;
                tx_data_d = hold_q;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timed_out) begin
                    state_d = IDLE;
                    owner_d = '0;
                    tx_err_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    owner_d = '0;
                end else if (timed_out) begin
                    state_d = IDLE;
                    owner_d = '0;
                    tx_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // State and output registers; reset drops any captured byte and restores index 0 priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= IW'(N_REQ - 1);
            hold_q <= '0;
            gnt_q <= '0;
            owner_q <= '0;
            busy_q <= 1'b0;
            tx_ena_q <= 1'b0;
            tx_data_q <= '0;
            tx_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            hold_q <= hold_d;
            gnt_q <= gnt_d;
            owner_q <= owner_d;
            busy_q <= busy_d;
            tx_ena_q <= tx_ena_d;
            tx_data_q <= tx_data_d;
            tx_err_q <= tx_err_d;
        end
    end

    assign gnt = gnt_q;
    assign owner = owner_q;
    assign arb_busy = busy_q;
    assign tx_ena = tx_ena_q;
    assign tx_data = tx_data_q;
    assign tx_err = tx_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_data = '0;
    logic        tx_busy = 1'b0;
    logic [3:0]  gnt, owner, tx_data;
    logic        arb_busy, tx_ena, tx_err;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .D_WIDTH(4), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .owner    (owner),
        .arb_busy (arb_busy),
        .tx_ena   (tx_ena),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_err   (tx_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic serve(input int idx, input logic [3:0] d, input string tag);
        int n = 0;
        while (gnt == 4'b0 && n < 20) begin
            step();
            n++;
        end
        check({tag, " gnt"}, 32'(gnt), 32'(1) << idx);
        check({tag, " owner"}, 32'(owner), 32'(1) << idx);
        step();
        check({tag, " gnt pulse"}, 32'(gnt), 0);
        check({tag, " tx_ena"}, 32'(tx_ena), 1);
        check({tag, " tx_data"}, 32'(tx_data), 32'(d));
        tx_busy = 1'b1;
        step();
        check({tag, " owner held"}, 32'(owner), 32'(1) << idx);
        tx_busy = 1'b0;
        step();
        check({tag, " owner released"}, 32'(owner), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(2);
        check("rst gnt", 32'(gnt), 0);
        check("rst owner", 32'(owner), 0);
        check("rst arb_busy", 32'(arb_busy), 0);
        check("rst tx_ena", 32'(tx_ena), 0);
        check("rst tx_data", 32'(tx_data), 0);
        check("rst tx_err", 32'(tx_err), 0);
        rst = 1'b0;

        req = 4'b0100;
        req_data = 16'h0A00;
        step();
        check("t1 gnt", 32'(gnt), 'h4);
        check("t1 owner", 32'(owner), 'h4);
        check("t1 arb_busy", 32'(arb_busy), 1);
        check("t1 early tx_ena", 32'(tx_ena), 0);
        req = '0;
        step();
        check("t1 gnt pulse", 32'(gnt), 0);
        check("t1 tx_ena", 32'(tx_ena), 1);
        check("t1 tx_data", 32'(tx_data), 'hA);
        step();
        check("t1 tx_ena pulse", 32'(tx_ena), 0);
        tx_busy = 1'b1;
        step(3);
        check("t1 owner busy", 32'(owner), 'h4);
        check("t1 tx_data held", 32'(tx_data), 'hA);
        tx_busy = 1'b0;
        step();
        check("t1 owner done", 32'(owner), 0);
        check("t1 arb idle", 32'(arb_busy), 0);
        step();
        check("t1 no regrant", 32'(gnt), 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        req_data = 16'h4321;
        serve(0, 4'h1, "rr0");
        serve(1, 4'h2, "rr1");
        serve(2, 4'h3, "rr2");
        serve(3, 4'h4, "rr3");
        serve(0, 4'h1, "rr4");
        req = '0;

        req = 4'b1000;
        req_data = 16'h7050;
        serve(3, 4'h7, "wrap3");
        req = 4'b1010;
        serve(1, 4'h5, "wrap1");
        req = '0;

        req = 4'b0001;
        req_data = 16'h0009;
        step();
        check("mr gnt", 32'(gnt), 'h1);
        req = '0;
        step();
        tx_busy = 1'b1;
        step();
        check("mr wait_done", 32'(arb_busy), 1);
        #2 rst = 1'b1;
        #1;
        check("mr async gnt", 32'(gnt), 0);
        check("mr async owner", 32'(owner), 0);
        check("mr async arb_busy", 32'(arb_busy), 0);
        check("mr async tx_ena", 32'(tx_ena), 0);
        check("mr async tx_data", 32'(tx_data), 0);
        tx_busy = 1'b0;
        step();
        rst = 1'b0;
        req = 4'b0010;
        req_data = 16'h00C0;
        step();
        check("mr regrant", 32'(gnt), 'h2);
        check("mr no stale tx_ena", 32'(tx_ena), 0);
        serve(1, 4'hC, "mr");
        req = '0;

        tx_busy = 1'b1;
        req = 4'b0100;
        req_data = 16'h0B00;
        step(3);
        check("bz gnt", 32'(gnt), 0);
        check("bz tx_ena", 32'(tx_ena), 0);
        check("bz arb_busy", 32'(arb_busy), 0);
        tx_busy = 1'b0;
        serve(2, 4'hB, "bz");
        req = '0;

        req = 4'b0001;
        req_data = 16'h0006;
        step();
        check("to gnt", 32'(gnt), 'h1);
        req = '0;
        step();
        check("to tx_ena", 32'(tx_ena), 1);
`ifdef UART_ARB_TIMEOUT_EN
        step(15);
        check("to early err", 32'(tx_err), 0);
        check("to owner", 32'(owner), 'h1);
        step();
        check("to err", 32'(tx_err), 1);
        check("to owner clr", 32'(owner), 0);
        check("to idle", 32'(arb_busy), 0);
        step();
        check("to err pulse", 32'(tx_err), 0);
`else
        begin
            logic err_seen = 1'b0;
            repeat (30) begin
                step();
                err_seen |= tx_err;
            end
            check("to no err", 32'(err_seen), 0);
            check("to still busy", 32'(arb_busy), 1);
            check("to owner held", 32'(owner), 'h1);
            tx_busy = 1'b1;
            step();
            tx_busy = 1'b0;
            step();
            check("to done", 32'(arb_busy), 0);
        end
`endif
        req = 4'b0010;
        req_data = 16'h00D0;
        serve(1, 4'hD, "post");
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
